// File: rtl/regfile16_onehot.sv
// rtl/regfile16_onehot.sv - 16-entry register file, one-hot write select, two registered read ports
// Same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile16_onehot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [15:0]       wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        ra,
    input  logic [3:0]        rb,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_err,
    output logic              sel_err
);

    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              sel_err_q, sel_err_d;

    logic sel_onehot;
    logic write_ok;
    logic write_bad;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign sel_onehot = (wsel != 16'd0) && ((wsel & (wsel - 16'd1)) == 16'd0);
    assign write_ok   = we && sel_onehot;
    assign write_bad  = we && !sel_onehot;

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            regs_d[k] = regs_q[k];
            if (write_ok && wsel[k]) begin
                regs_d[k] = wdata;
            end
        end
    end

    always_comb begin
        rdata_a_d = regs_q[ra];
        rdata_b_d = regs_q[rb];
`ifdef REGFILE_BYPASS_EN
        if (write_ok && wsel[ra]) begin
            rdata_a_d = wdata;
        end
        if (write_ok && wsel[rb]) begin
            rdata_b_d = wdata;
        end
`endif
    end

    // A bad write in the same cycle as clr_err keeps the flag set.
    always_comb begin
        sel_err_d = sel_err_q;
        if (clr_err) begin
            sel_err_d = 1'b0;
        end
        if (write_bad) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                regs_q[k] <= '0;
            end
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                regs_q[k] <= regs_d[k];
            end
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_regfile16_onehot.sv
// tb/tb_regfile16_onehot.sv - scoreboard bench for regfile16_onehot
module tb_regfile16_onehot;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [15:0] wsel = 16'd0;
    logic [7:0]  wdata = 8'd0;
    logic [3:0]  ra = 4'd0;
    logic [3:0]  rb = 4'd0;
    logic        clr_err = 1'b0;
    logic [7:0]  rdata_a;
    logic [7:0]  rdata_b;
    logic        sel_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       err;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];

    logic [7:0] mdl [16];
    logic       mdl_err = 1'b0;

    regfile16_onehot #(.DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wsel    (wsel),
        .wdata   (wdata),
        .ra      (ra),
        .rb      (rb),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .clr_err (clr_err),
        .sel_err (sel_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Drive one cycle, predict the post-edge outputs, and record what the DUT shows.
    task automatic cycle(input logic rst_i, input logic we_i, input logic [15:0] wsel_i,
                         input logic [7:0] wdata_i, input logic [3:0] ra_i,
                         input logic [3:0] rb_i, input logic clr_i);
        snap_t e, o;
        logic  legal;
        rst = rst_i; we = we_i; wsel = wsel_i; wdata = wdata_i;
        ra = ra_i; rb = rb_i; clr_err = clr_i;
        legal = we_i && ($countones(wsel_i) == 1);
        if (rst_i) begin
            e.a = 8'h00; e.b = 8'h00; e.err = 1'b0;
            for (int k = 0; k < 16; k++) mdl[k] = 8'h00;
            mdl_err = 1'b0;
        end else begin
            e.a = mdl[ra_i];
            e.b = mdl[rb_i];
`ifdef REGFILE_BYPASS_EN
            if (legal && wsel_i[ra_i]) e.a = wdata_i;
            if (legal && wsel_i[rb_i]) e.b = wdata_i;
`endif
            if (we_i && !legal) mdl_err = 1'b1;
            else if (clr_i) mdl_err = 1'b0;
            e.err = mdl_err;
            if (legal) begin
                for (int k = 0; k < 16; k++) if (wsel_i[k]) mdl[k] = wdata_i;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.a = rdata_a; o.b = rdata_b; o.err = sel_err;
        obs_q.push_back(o);
        rst = 1'b0; we = 1'b0; clr_err = 1'b0;
    endtask

    task automatic idle_read(input logic [3:0] ra_i, input logic [3:0] rb_i);
        cycle(1'b0, 1'b0, 16'd0, 8'd0, ra_i, rb_i, 1'b0);
    endtask

    task automatic test_reset;
        snap_t e, o;
        cycle(1'b1, 1'b0, 16'd0, 8'd0, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) idle_read(4'(i), 4'(15 - i));
        checks++;
        if (sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_sel_err: got %0b required 0", sel_err);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.a !== 8'h00 || o.b !== 8'h00 || o.err !== 1'b0 || o.a !== e.a || o.b !== e.b) begin
                errors++;
                $display("FAIL reset_read: got a=%h b=%h err=%b required a=00 b=00 err=0", o.a, o.b, o.err);
            end
        end
    endtask

    task automatic test_legal_write;
        snap_t e, o;
        cycle(1'b0, 1'b1, 16'h0008, 8'hA5, 4'd0, 4'd0, 1'b0);
        idle_read(4'd3, 4'd4);
        checks++;
        if (rdata_a !== 8'hA5 || rdata_b !== 8'h00) begin
            errors++;
            $display("FAIL legal_write: got a=%h b=%h required a=a5 b=00", rdata_a, rdata_b);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL legal_write_sb: got a=%h b=%h err=%b required a=%h b=%h err=%b",
                         o.a, o.b, o.err, e.a, e.b, e.err);
            end
        end
    endtask

    task automatic test_illegal_select;
        snap_t e, o;
        cycle(1'b0, 1'b1, 16'h0002, 8'h11, 4'd0, 4'd0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0004, 8'h22, 4'd0, 4'd0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0006, 8'hFF, 4'd0, 4'd0, 1'b0);
        checks++;
        if (sel_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_two_bits: got sel_err=%b required 1", sel_err);
        end
        cycle(1'b0, 1'b1, 16'h0000, 8'h33, 4'd1, 4'd2, 1'b0);
        checks++;
        if (sel_err !== 1'b1 || rdata_a !== 8'h11 || rdata_b !== 8'h22) begin
            errors++;
            $display("FAIL illegal_zero_sel: got err=%b a=%h b=%h required err=1 a=11 b=22",
                     sel_err, rdata_a, rdata_b);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL illegal_sb: got a=%h b=%h err=%b required a=%h b=%h err=%b",
                         o.a, o.b, o.err, e.a, e.b, e.err);
            end
        end
    endtask

    task automatic test_err_clear;
        snap_t e, o;
        cycle(1'b0, 1'b0, 16'd0, 8'd0, 4'd1, 4'd2, 1'b1);
        checks++;
        if (sel_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone: got sel_err=%b required 0", sel_err);
        end
        cycle(1'b0, 1'b1, 16'h0003, 8'h5A, 4'd0, 4'd1, 1'b1);
        checks++;
        if (sel_err !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set: got sel_err=%b required 1", sel_err);
        end
        cycle(1'b0, 1'b0, 16'd0, 8'd0, 4'd0, 4'd1, 1'b1);
        cycle(1'b0, 1'b0, 16'hFFFF, 8'hEE, 4'd0, 4'd15, 1'b0);
        checks++;
        if (sel_err !== 1'b0) begin
            errors++;
            $display("FAIL we0_ignored: got sel_err=%b required 0", sel_err);
        end
        idle_read(4'd0, 4'd15);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL err_clear_sb: got a=%h b=%h err=%b required a=%h b=%h err=%b",
                         o.a, o.b, o.err, e.a, e.b, e.err);
            end
        end
    endtask

    task automatic test_same_cycle;
        snap_t e, o;
        logic [7:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 8'h77;
`else
        want = 8'h10;
`endif
        cycle(1'b0, 1'b1, 16'h0080, 8'h10, 4'd0, 4'd0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0080, 8'h77, 4'd7, 4'd7, 1'b0);
        checks++;
        if (rdata_a !== want || rdata_b !== want) begin
            errors++;
            $display("FAIL same_cycle: got a=%h b=%h required %h", rdata_a, rdata_b, want);
        end
        idle_read(4'd7, 4'd0);
        checks++;
        if (rdata_a !== 8'h77) begin
            errors++;
            $display("FAIL same_cycle_next: got a=%h required 77", rdata_a);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL same_cycle_sb: got a=%h b=%h err=%b required a=%h b=%h err=%b",
                         o.a, o.b, o.err, e.a, e.b, e.err);
            end
        end
    endtask

    task automatic test_back_to_back;
        snap_t e, o;
        logic [15:0] s;
        logic        w;
        for (int i = 0; i < 300; i++) begin
            w = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) s = 16'($urandom);
            else s = 16'h0001 << $urandom_range(0, 15);
            cycle(1'b0, w, s, 8'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 5) == 0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back_sb: got a=%h b=%h err=%b required a=%h b=%h err=%b",
                         o.a, o.b, o.err, e.a, e.b, e.err);
            end
        end
    endtask

    task automatic test_reset_mid;
        snap_t e, o;
        cycle(1'b0, 1'b1, 16'h0000, 8'h00, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, 16'h0001 << i, 8'(8'h40 + i), 4'd0, 4'd0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0020, 8'h45, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) idle_read(4'(i), 4'(15 - i));
        checks++;
        if (sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_err: got sel_err=%b required 0", sel_err);
        end
        for (int i = 0; i < 7; i++) begin
            void'(exp_q.pop_front());
            void'(obs_q.pop_front());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.a !== 8'h00 || o.b !== 8'h00 || o.err !== 1'b0 || o !== e) begin
                errors++;
                $display("FAIL reset_mid_read: got a=%h b=%h err=%b required a=00 b=00 err=0",
                         o.a, o.b, o.err);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mdl[k] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_legal_write;
        test_illegal_select;
        test_err_clear;
        test_same_cycle;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
